// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back stage: latches the MEM-stage entry,
// extracts load data, selects the write-back value and counts retired instructions.
module mem_wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_reg_write,
    input  logic [4:0]       in_rd,
    input  logic [1:0]       in_wd_sel,
    input  logic [2:0]       in_ld_size,
    input  logic [1:0]       in_addr_lo,
    input  logic [XLEN-1:0]  in_alu_result,
    input  logic [XLEN-1:0]  in_mem_rdata,
    input  logic [XLEN-1:0]  in_pc_plus4,
    output logic             RFWr,
    output logic [4:0]       A3,
    output logic [XLEN-1:0]  WD,
    output logic             wb_valid,
    output logic             fwd_en,
    output logic [4:0]       fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic [CNT_W-1:0] instret
);

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic [4:0]      rd;
        logic [1:0]      wd_sel;
        logic [2:0]      ld_size;
        logic [1:0]      addr_lo;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] mem_rdata;
        logic [XLEN-1:0] pc_plus4;
    } wb_entry_t;

    wb_entry_t ent_d, ent_q;

    assign ent_d = '{
        valid:      in_valid,
        reg_write:  in_reg_write,
        rd:         in_rd,
        wd_sel:     in_wd_sel,
        ld_size:    in_ld_size,
        addr_lo:    in_addr_lo,
        alu_result: in_alu_result,
        mem_rdata:  in_mem_rdata,
        pc_plus4:   in_pc_plus4
    };

    // A flushed slot only needs valid cleared; the stale fields are masked by it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q   <= '0;
            instret <= '0;
        end else if (flush) begin
            ent_q.valid <= 1'b0;
        end else if (!stall) begin
            ent_q <= ent_d;
            if (in_valid)
                instret <= instret + CNT_W'(1);
        end
    end

    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] wd_mux;

    always_comb begin
        case (ent_q.addr_lo)
            2'd0:    ld_byte = ent_q.mem_rdata[7:0];
            2'd1:    ld_byte = ent_q.mem_rdata[15:8];
            2'd2:    ld_byte = ent_q.mem_rdata[23:16];
            default: ld_byte = ent_q.mem_rdata[31:24];
        endcase
        ld_half = ent_q.addr_lo[1] ? ent_q.mem_rdata[31:16] : ent_q.mem_rdata[15:0];

        ld_data = '0;
        case (ent_q.ld_size)
            3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b010:  ld_data = ent_q.mem_rdata;
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = '0;
        endcase

        case (ent_q.wd_sel)
            2'b00:   wd_mux = ent_q.alu_result;
            2'b01:   wd_mux = ld_data;
            2'b10:   wd_mux = ent_q.pc_plus4;
            default: wd_mux = '0;
        endcase
    end

    // x0 is hardwired zero, so writes to it never reach the register file.
    assign RFWr     = ent_q.valid & ent_q.reg_write & (ent_q.rd != 5'd0);
    assign A3       = ent_q.rd;
    assign WD       = wd_mux;
    assign wb_valid = ent_q.valid;
    assign fwd_en   = RFWr;
    assign fwd_rd   = A3;
    assign fwd_data = WD;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected write-back values are queued when
// stimulus is driven and compared after the capturing clock edge.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid, in_reg_write;
    logic [4:0]  in_rd;
    logic [1:0]  in_wd_sel, in_addr_lo;
    logic [2:0]  in_ld_size;
    logic [31:0] in_alu_result, in_mem_rdata, in_pc_plus4;
    logic        RFWr, wb_valid, fwd_en;
    logic [4:0]  A3, fwd_rd;
    logic [31:0] WD, fwd_data, instret;
    logic        RFWr4, wb_valid4, fwd_en4;
    logic [4:0]  A3_4, fwd_rd4;
    logic [31:0] WD4, fwd_data4;
    logic [3:0]  instret4;

    typedef struct {
        logic        rfwr;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        vld;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_cnt = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_reg_write(in_reg_write), .in_rd(in_rd), .in_wd_sel(in_wd_sel),
        .in_ld_size(in_ld_size), .in_addr_lo(in_addr_lo), .in_alu_result(in_alu_result),
        .in_mem_rdata(in_mem_rdata), .in_pc_plus4(in_pc_plus4), .RFWr(RFWr), .A3(A3),
        .WD(WD), .wb_valid(wb_valid), .fwd_en(fwd_en), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data), .instret(instret));

    // Narrow counter copy so the wrap from all-ones can be reached in a few cycles.
    mem_wb_stage #(.XLEN(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_reg_write(in_reg_write), .in_rd(in_rd), .in_wd_sel(in_wd_sel),
        .in_ld_size(in_ld_size), .in_addr_lo(in_addr_lo), .in_alu_result(in_alu_result),
        .in_mem_rdata(in_mem_rdata), .in_pc_plus4(in_pc_plus4), .RFWr(RFWr4), .A3(A3_4),
        .WD(WD4), .wb_valid(wb_valid4), .fwd_en(fwd_en4), .fwd_rd(fwd_rd4),
        .fwd_data(fwd_data4), .instret(instret4));

    task automatic set_in(input logic v, input logic rw, input logic [4:0] rd,
                          input logic [1:0] sel, input logic [2:0] sz, input logic [1:0] off,
                          input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] pc4);
        in_valid = v; in_reg_write = rw; in_rd = rd; in_wd_sel = sel; in_ld_size = sz;
        in_addr_lo = off; in_alu_result = alu; in_mem_rdata = rdata; in_pc_plus4 = pc4;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_wd(input logic [1:0] sel, input logic [2:0] sz,
                                             input logic [1:0] off, input logic [31:0] alu,
                                             input logic [31:0] rdata, input logic [31:0] pc4);
        logic [31:0] sh, ld;
        sh = rdata >> (8 * off);
        ld = 32'h0;
        if (sz == 3'b000) ld = 32'($signed(sh[7:0]));
        if (sz == 3'b100) ld = {24'h0, sh[7:0]};
        if (sz == 3'b001) ld = 32'($signed(off[1] ? rdata[31:16] : rdata[15:0]));
        if (sz == 3'b101) ld = {16'h0, (off[1] ? rdata[31:16] : rdata[15:0])};
        if (sz == 3'b010) ld = rdata;
        case (sel)
            2'b00:   return alu;
            2'b01:   return ld;
            2'b10:   return pc4;
            default: return 32'h0;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1; stall = $urandom_range(0, 1); flush = $urandom_range(0, 1);
        set_in(1'b1, 1'b1, 5'($urandom), 2'($urandom), 3'($urandom), 2'($urandom),
               $urandom, $urandom, $urandom);
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (RFWr !== 1'b0 || WD !== 32'h0 || wb_valid !== 1'b0 || instret !== 32'h0 ||
                A3 !== 5'd0 || fwd_en !== 1'b0 || instret4 !== 4'h0) begin
                miscompares++;
                $display("FAIL reset[%0d]: RFWr=%b WD=%h wb_valid=%b instret=%0d A3=%0d, want all 0",
                         i, RFWr, WD, wb_valid, instret, A3);
            end
        end
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        exp_cnt = 0;
    endtask

    // Pops the next scoreboard entry and compares all WB outputs plus both counters.
    task automatic test_apply(input string name);
        step();
        vectors++;
        if (sbq.size() == 0) begin
            miscompares++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sbq.pop_front();
            if (RFWr !== e.rfwr || A3 !== e.a3 || WD !== e.wd || wb_valid !== e.vld ||
                fwd_en !== e.rfwr || fwd_rd !== e.a3 || fwd_data !== e.wd ||
                instret !== exp_cnt || instret4 !== exp_cnt[3:0]) begin
                miscompares++;
                $display("FAIL %s: got RFWr=%b A3=%0d WD=%h vld=%b cnt=%0d cnt4=%0d, want RFWr=%b A3=%0d WD=%h vld=%b cnt=%0d",
                         name, RFWr, A3, WD, wb_valid, instret, instret4,
                         e.rfwr, e.a3, e.wd, e.vld, exp_cnt);
            end
        end
    endtask

    task automatic test_alu();
        set_in(1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 2'd0, 32'h1234_5678, 32'h0, 32'h0);
        sbq.push_back('{1'b1, 5'd5, 32'h1234_5678, 1'b1});
        exp_cnt++;
        test_apply("alu");
        if (instret !== 32'd1) begin
            miscompares++;
            $display("FAIL alu_instret: got %0d want 1", instret);
        end
        vectors++;
    endtask

    task automatic test_loads();
        logic [2:0]  sz[5]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [1:0]  off[5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1};
        logic [31:0] exp[5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                                32'h0000_7F01, 32'h80FF_7F01};
        // Back-to-back loads: a new entry every cycle, no bubbles.
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 1'b1, 5'(10 + i), 2'b01, sz[i], off[i], 32'hDEAD_BEEF,
                   32'h80FF_7F01, 32'h0000_0400);
            sbq.push_back('{1'b1, 5'(10 + i), exp[i], 1'b1});
            exp_cnt++;
            test_apply($sformatf("load%0d", i));
        end
    endtask

    task automatic test_x0_sel();
        // x0 write suppressed; WD still driven
        set_in(1'b1, 1'b1, 5'd0, 2'b00, 3'b000, 2'd0, 32'hCAFE_0001, 32'h0, 32'h0);
        sbq.push_back('{1'b0, 5'd0, 32'hCAFE_0001, 1'b1}); exp_cnt++;
        test_apply("x0");
        set_in(1'b1, 1'b1, 5'd7, 2'b11, 3'b010, 2'd0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
        sbq.push_back('{1'b1, 5'd7, 32'h0, 1'b1}); exp_cnt++;
        test_apply("sel11");
        set_in(1'b1, 1'b1, 5'd1, 2'b10, 3'b000, 2'd0, 32'h5555_5555, 32'h0, 32'h0000_0104);
        sbq.push_back('{1'b1, 5'd1, 32'h0000_0104, 1'b1}); exp_cnt++;
        test_apply("jal");
        set_in(1'b1, 1'b0, 5'd9, 2'b00, 3'b000, 2'd0, 32'h0000_0099, 32'h0, 32'h0);
        sbq.push_back('{1'b0, 5'd9, 32'h0000_0099, 1'b1}); exp_cnt++;
        test_apply("no_regwrite");
        set_in(1'b0, 1'b1, 5'd9, 2'b00, 3'b000, 2'd0, 32'h0000_0077, 32'h0, 32'h0);
        sbq.push_back('{1'b0, 5'd9, 32'h0000_0077, 1'b0});
        test_apply("invalid");
        set_in(1'b1, 1'b1, 5'd3, 2'b01, 3'b011, 2'd0, 32'h0, 32'hFFFF_FFFF, 32'h0);
        sbq.push_back('{1'b1, 5'd3, 32'h0, 1'b1}); exp_cnt++;
        test_apply("bad_ldsize");
    endtask

    task automatic test_random();
        logic v, rw; logic [4:0] rd; logic [1:0] sel, off; logic [2:0] sz;
        logic [31:0] alu, rdata, pc4;
        for (int i = 0; i < 24; i++) begin
            v = $urandom_range(0, 3) != 0; rw = $urandom_range(0, 1); rd = 5'($urandom);
            sel = 2'($urandom); sz = 3'($urandom); off = 2'($urandom);
            alu = $urandom; rdata = $urandom; pc4 = $urandom;
            set_in(v, rw, rd, sel, sz, off, alu, rdata, pc4);
            sbq.push_back('{v & rw & (rd != 0), rd, model_wd(sel, sz, off, alu, rdata, pc4), v});
            if (v) exp_cnt++;
            test_apply($sformatf("rand%0d", i));
        end
    endtask

    task automatic test_stall_flush();
        set_in(1'b1, 1'b1, 5'd12, 2'b00, 3'b000, 2'd0, 32'hABCD_0012, 32'h0, 32'h0);
        sbq.push_back('{1'b1, 5'd12, 32'hABCD_0012, 1'b1}); exp_cnt++;
        test_apply("pre_stall");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, 5'(20 + i), 2'b00, 3'b000, 2'd0, 32'(i + 100), 32'h0, 32'h0);
            sbq.push_back('{1'b1, 5'd12, 32'hABCD_0012, 1'b1});
            test_apply($sformatf("stall%0d", i));
        end
        flush = 1'b1;
        sbq.push_back('{1'b0, 5'd0, 32'h0, 1'b0});
        step();
        vectors++;
        e = sbq.pop_front();
        if (wb_valid !== e.vld || RFWr !== e.rfwr || fwd_en !== e.rfwr || instret !== exp_cnt) begin
            miscompares++;
            $display("FAIL flush_stall: got vld=%b RFWr=%b cnt=%0d want vld=0 RFWr=0 cnt=%0d",
                     wb_valid, RFWr, instret, exp_cnt);
        end
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_wrap_and_rst();
        rst = 1'b1; step(); rst = 1'b0; exp_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            set_in(1'b1, 1'b1, 5'd4, 2'b00, 3'b000, 2'd0, 32'(i), 32'h0, 32'h0);
            sbq.push_back('{1'b1, 5'd4, 32'(i), 1'b1}); exp_cnt++;
            test_apply($sformatf("wrap%0d", i));
        end
        vectors++;
        if (instret4 !== 4'h0 || instret !== 32'd16) begin
            miscompares++;
            $display("FAIL wrap: got cnt4=%0d cnt=%0d want cnt4=0 cnt=16", instret4, instret);
        end
        set_in(1'b1, 1'b1, 5'd8, 2'b00, 3'b000, 2'd0, 32'h0000_0888, 32'h0, 32'h0);
        sbq.push_back('{1'b1, 5'd8, 32'h0000_0888, 1'b1}); exp_cnt++;
        test_apply("pre_rst_stall");
        stall = 1'b1; rst = 1'b1;
        step();
        vectors++;
        if (RFWr !== 1'b0 || A3 !== 5'd0 || WD !== 32'h0 || wb_valid !== 1'b0 ||
            fwd_en !== 1'b0 || instret !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_in_stall: got RFWr=%b A3=%0d WD=%h vld=%b cnt=%0d want all 0",
                     RFWr, A3, WD, wb_valid, instret);
        end
        stall = 1'b0; rst = 1'b0; exp_cnt = 0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        set_in(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 2'd0, 32'h0, 32'h0, 32'h0);
        #1;
        test_reset();
        test_alu();
        test_loads();
        test_x0_sel();
        test_random();
        test_stall_flush();
        test_wrap_and_rst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
